mem_access_unit: RTL

- Pipeline MEM stage of the RV64 core.
- Consumes the EX-stage `execute_data_t` bundle and drives the data-bus request side (the initiator end of dbus).
- Waits for the bus response, then aligns and extends load data into a `memory_data_t` bundle for WB.
- Stalls upstream while a bus transaction is outstanding or WB is back-pressured.

---
 rtl/mem_access_unit_pkg.sv | 52 +++++
 rtl/mem_access_unit_load_align.sv | 27 ++
 rtl/mem_access_unit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared pipeline types for the MEM stage: EX/MEM and MEM/WB bundles,
// access-size encoding and the MEM-stage state enum.
package mem_access_unit_pkg;

  localparam int DEFAULT_MMIO_BIT = 31;

  typedef enum logic [2:0] {
    MSize_zero   = 3'd0,
    MSize_8bits  = 3'd1,
    MSize_16bits = 3'd2,
    MSize_32bits = 3'd3,
    MSize_64bits = 3'd4
  } MemSizeType;

  typedef enum logic {
    MAU_IDLE,
    MAU_ACCESS
  } mau_state_t;

  typedef struct packed {
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    MemSizeType MemSize;
  } control_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] raw_instr;
    control_t    ctl;
    logic [4:0]  dst;
    logic [63:0] alu_out;
    logic [63:0] MemWriteData;
    logic [11:0] csr;
    logic [63:0] csr_rdata;
    logic        valid;
  } execute_data_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] raw_instr;
    control_t    ctl;
    logic [4:0]  dst;
    logic [63:0] alu_out;
    logic [11:0] csr;
    logic [63:0] csr_rdata;
    logic [63:0] MemReadData;
    logic        skip;
    logic        valid;
  } memory_data_t;

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Combinational load alignment: shifts the raw 64-bit bus word down to the
// addressed byte lane, truncates to the access size and sign/zero-extends.
module load_data_align
  import mem_access_unit_pkg::*;
(
  input  logic [63:0] dresp_data,
  input  logic [2:0]  off,
  input  MemSizeType  mem_size,
  input  logic        is_unsigned,
  output logic [63:0] result
);

  logic [63:0] shifted;

  assign shifted = dresp_data >> {off, 3'b000};

  always_comb begin
    result = shifted;
    case (mem_size)
      MSize_8bits:  result = {{56{~is_unsigned & shifted[7]}},  shifted[7:0]};
      MSize_16bits: result = {{48{~is_unsigned & shifted[15]}}, shifted[15:0]};
      MSize_32bits: result = {{32{~is_unsigned & shifted[31]}}, shifted[31:0]};
      default:      result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: issues data-bus requests for loads/stores, waits for completion
// and hands an aligned, extended result bundle to WB.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int MMIO_BIT = DEFAULT_MMIO_BIT
) (
  input  logic          clk,
  input  logic          reset_n,
  input  execute_data_t ex_in,
  input  logic          ex_valid,
  output logic          ex_ready,
  output memory_data_t  mem_out,
  output logic          mem_valid,
  input  logic          wb_ready,
  output logic          misalign,
  output logic          dreq_valid,
  output logic [63:0]   dreq_addr,
  output MemSizeType    dreq_size,
  output logic [7:0]    dreq_strobe,
  output logic [63:0]   dreq_data,
  input  logic          dresp_addr_ok,
  input  logic          dresp_data_ok,
  input  logic [63:0]   dresp_data
);

  function automatic logic [3:0] size_bytes(input MemSizeType s);
    case (s)
      MSize_8bits:  return 4'd1;
      MSize_16bits: return 4'd2;
      MSize_32bits: return 4'd4;
      MSize_64bits: return 4'd8;
      default:      return 4'd0;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] off, input MemSizeType s);
    case (s)
      MSize_16bits: return off[0];
      MSize_32bits: return |off[1:0];
      MSize_64bits: return |off;
      default:      return 1'b0;
    endcase
  endfunction

  function automatic memory_data_t build_out(input execute_data_t e, input logic [63:0] rdata,
                                             input logic mem_op);
    memory_data_t m;
    m             = '0;
    m.pc          = e.pc;
    m.raw_instr   = e.raw_instr;
    m.ctl         = e.ctl;
    m.dst         = e.dst;
    m.alu_out     = e.alu_out;
    m.csr         = e.csr;
    m.csr_rdata   = e.csr_rdata;
    m.MemReadData = rdata;
    m.skip        = mem_op & ~e.alu_out[MMIO_BIT];
    m.valid       = e.valid;
    return m;
  endfunction

  mau_state_t    state_reg, state_next;
  execute_data_t req_reg;
  memory_data_t  mem_out_reg, mem_out_next;
  logic          mem_valid_reg, misalign_reg, misalign_next;
  logic          req_load, load_out;
  logic          out_free, accept, ex_is_mem, ex_misaligned;
  logic [2:0]    req_off;
  logic [3:0]    req_bytes;
  logic [7:0]    strobe_lanes;
  logic [63:0]   load_data;
  logic          unused_addr_ok;

  // Address acceptance carries no meaning here; only data_ok closes a transaction.
  assign unused_addr_ok = dresp_addr_ok;

  assign out_free      = ~mem_valid_reg | wb_ready;
  assign ex_ready      = (state_reg == MAU_IDLE) & out_free;
  assign accept        = ex_valid & ex_ready;
  // An illegal size demotes a memory op to a plain pass-through.
  assign ex_is_mem     = (ex_in.ctl.MemRead | ex_in.ctl.MemWrite) & (ex_in.ctl.MemSize != MSize_zero);
  assign ex_misaligned = is_misaligned(ex_in.alu_out[2:0], ex_in.ctl.MemSize);

  assign req_off   = req_reg.alu_out[2:0];
  assign req_bytes = size_bytes(req_reg.ctl.MemSize);

  for (genvar gi = 0; gi < 8; gi++) begin : g_strobe
    assign strobe_lanes[gi] = ({1'b0, req_off} <= 4'(gi)) && (4'(gi) < ({1'b0, req_off} + req_bytes));
  end

  assign dreq_valid  = (state_reg == MAU_ACCESS);
  assign dreq_addr   = req_reg.alu_out;
  assign dreq_size   = req_reg.ctl.MemSize;
  assign dreq_strobe = (dreq_valid & req_reg.ctl.MemWrite) ? strobe_lanes : 8'h00;
  assign dreq_data   = req_reg.MemWriteData << {req_off, 3'b000};

  load_data_align u_align (
    .dresp_data  (dresp_data),
    .off         (req_off),
    .mem_size    (req_reg.ctl.MemSize),
    .is_unsigned (req_reg.raw_instr[14]),
    .result      (load_data)
  );

  always_comb begin
    state_next    = state_reg;
    req_load      = 1'b0;
    load_out      = 1'b0;
    mem_out_next  = mem_out_reg;
    misalign_next = 1'b0;
    case (state_reg)
      MAU_IDLE: begin
        if (accept) begin
          if (ex_is_mem && !ex_misaligned) begin
            req_load   = 1'b1;
            state_next = MAU_ACCESS;
          end else begin
            load_out      = 1'b1;
            mem_out_next  = build_out(ex_in, 64'd0, ex_is_mem);
            misalign_next = ex_is_mem & ex_misaligned;
          end
        end
      end
      MAU_ACCESS: begin
        // Output register was free at accept and nothing refilled it since.
        if (dresp_data_ok) begin
          load_out     = 1'b1;
          state_next   = MAU_IDLE;
          mem_out_next = build_out(req_reg, req_reg.ctl.MemRead ? load_data : 64'd0, 1'b1);
        end
      end
      default: state_next = MAU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= MAU_IDLE;
      req_reg       <= '0;
      mem_out_reg   <= '0;
      mem_valid_reg <= 1'b0;
      misalign_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (req_load) req_reg <= ex_in;
      if (load_out) begin
        mem_out_reg   <= mem_out_next;
        misalign_reg  <= misalign_next;
        mem_valid_reg <= 1'b1;
      end else if (wb_ready) begin
        mem_valid_reg <= 1'b0;
      end
    end
  end

  assign mem_out   = mem_out_reg;
  assign mem_valid = mem_valid_reg;
  assign misalign  = misalign_reg;

endmodule
